// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART TX packet scheduler and its picker.
package uart_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_e;

  localparam logic [7:0] sat_count_max = 8'hFF;

endpackage

// File: rtl/uart_tx_sched_rr_pick.sv
// Combinational rotate-priority picker: the first asserted request at or after
// ptr_i (wrapping modulo num_req_p) wins.
module rr_pick #(
  parameter int num_req_p = 3,
  parameter int ptr_w_p   = $clog2(num_req_p)
) (
  input  logic [num_req_p-1:0] req_i,
  input  logic [ptr_w_p-1:0]   ptr_i,
  output logic [ptr_w_p-1:0]   idx_o,
  output logic                 any_o
);

  int                 pos;
  logic [ptr_w_p-1:0] pos_idx;

  // NOTE: every output and temporary gets a default before the loop so no path
  // through the block leaves a value unassigned, which would infer a latch.
  always_comb begin
    idx_o   = '0;
    any_o   = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int i = 0; i < num_req_p; i++) begin
      pos = int'(ptr_i) + i;
      if (pos >= num_req_p) pos = pos - num_req_p;
      pos_idx = ptr_w_p'(pos);
      if (!any_o && req_i[pos_idx]) begin
        any_o = 1'b1;
        idx_o = pos_idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Packet-level round-robin scheduler sharing one UART TX AXI-stream port; the
// winner keeps the port until tlast, with a stall watchdog for dead sources.
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int num_req_p    = 3,
  parameter int data_width_p = 8,
  parameter int timeout_p    = 1024
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [num_req_p-1:0]              req_valid_i,
  input  logic [num_req_p*data_width_p-1:0] req_data_i,
  input  logic [num_req_p-1:0]              req_last_i,
  output logic [num_req_p-1:0]              req_ready_o,
  output logic                              valid_o,
  output logic [data_width_p-1:0]           data_o,
  input  logic                              ready_i,
  output logic [num_req_p-1:0]              grant_o,
  output logic                              busy_o,
  output logic                              timeout_o,
  output logic [7:0]                        timeout_count_o
);

  localparam int ptr_w = $clog2(num_req_p);
  localparam int cnt_w = (timeout_p > 1) ? $clog2(timeout_p + 1) : 1;
  localparam logic [cnt_w-1:0] stall_last = (timeout_p > 0) ? cnt_w'(timeout_p - 1) : '0;

  state_e                                    state_q, state_d;
  logic [ptr_w-1:0]                          ptr_q, ptr_d;
  logic [ptr_w-1:0]                          gnt_q, gnt_d;
  logic [cnt_w-1:0]                          stall_q, stall_d;
  logic                                      timeout_q, timeout_d;
  logic [7:0]                                tcount_q, tcount_d;

  logic [ptr_w-1:0]                          pick_idx;
  logic                                      pick_any;
  logic [ptr_w-1:0]                          gnt_next;
  logic                                      lock_active;
  logic                                      handshake;
  logic [num_req_p-1:0][data_width_p-1:0]    req_data_a;

  assign req_data_a = req_data_i;

  rr_pick #(
    .num_req_p(num_req_p),
    .ptr_w_p  (ptr_w)
  ) u_pick (
    .req_i(req_valid_i),
    .ptr_i(ptr_q),
    .idx_o(pick_idx),
    .any_o(pick_any)
  );

  // Outputs are forced to their reset values for as long as reset_i is low,
  // so a mid-packet reset never exposes the in-flight byte.
  assign lock_active     = (state_q == LOCK) && reset_i;
  assign gnt_next        = (gnt_q == ptr_w'(num_req_p - 1)) ? '0 : gnt_q + 1'b1;
  assign valid_o         = lock_active && req_valid_i[gnt_q];
  assign data_o          = lock_active ? req_data_a[gnt_q] : '0;
  assign busy_o          = lock_active;
  assign handshake       = valid_o && ready_i;
  assign timeout_o       = timeout_q && reset_i;
  assign timeout_count_o = reset_i ? tcount_q : '0;

  always_comb begin
    req_ready_o = '0;
    grant_o     = '0;
    if (lock_active) begin
      req_ready_o[gnt_q] = ready_i;
      grant_o[gnt_q]     = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    stall_d   = stall_q;
    timeout_d = 1'b0;
    tcount_d  = tcount_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = LOCK;
          gnt_d   = pick_idx;
          stall_d = '0;
        end
      end
      LOCK: begin
        if (handshake) begin
          stall_d = '0;
          if (req_last_i[gnt_q]) begin
            state_d = IDLE;
            ptr_d   = gnt_next;
          end
        end else if (!req_valid_i[gnt_q] && (timeout_p != 0)) begin
          // A sink stall keeps valid high and therefore never feeds the watchdog.
          if (stall_q == stall_last) begin
            state_d   = IDLE;
            ptr_d     = gnt_next;
            timeout_d = 1'b1;
            if (tcount_q != sat_count_max) tcount_d = tcount_q + 8'd1;
          end else begin
            stall_d = stall_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      stall_q   <= '0;
      timeout_q <= 1'b0;
      tcount_q  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
      tcount_q  <= tcount_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: directed packets are queued per source,
// expected UART beats are queued in arbitration order and checked on handshake.
module tb_uart_tx_sched;

  localparam int N = 3;
  localparam int W = 8;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  typedef struct {
    int           src;
    logic [W-1:0] data;
    logic         last;
  } exp_t;

  logic           clk_i = 1'b0;
  logic           reset_i = 1'b0;
  logic [N-1:0]   req_valid_i = '0;
  logic [N*W-1:0] req_data_i = '0;
  logic [N-1:0]   req_last_i = '0;
  logic [N-1:0]   req_ready_o;
  logic           valid_o;
  logic [W-1:0]   data_o;
  logic           ready_i = 1'b1;
  logic [N-1:0]   grant_o;
  logic           busy_o;
  logic           timeout_o;
  logic [7:0]     timeout_count_o;

  uart_tx_sched #(
    .num_req_p   (N),
    .data_width_p(W),
    .timeout_p   (8)
  ) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .req_valid_i    (req_valid_i),
    .req_data_i     (req_data_i),
    .req_last_i     (req_last_i),
    .req_ready_o    (req_ready_o),
    .valid_o        (valid_o),
    .data_o         (data_o),
    .ready_i        (ready_i),
    .grant_o        (grant_o),
    .busy_o         (busy_o),
    .timeout_o      (timeout_o),
    .timeout_count_o(timeout_count_o)
  );

  always #5 clk_i = ~clk_i;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         hs_count = 0;
  int         hs_cyc[2048];
  int         to_pulses = 0;
  int         to_cyc = 0;
  int         gcount[N];
  beat_t      src_q[N][$];
  exp_t       exp_q[$];
  logic [N-1:0] src_hs = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic send(input int k, input logic [W-1:0] d, input logic l);
    src_q[k].push_back(beat_t'{d, l});
    exp_q.push_back(exp_t'{k, d, l});
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic wait_hs(input int n, input int max_cyc, input string name);
    int i;
    i = 0;
    do begin
      @(posedge clk_i);
      i++;
    end while (hs_count < n && i < max_cyc);
    if (hs_count < n) begin
      total++;
      bad++;
      $display("FAIL %s actual=%0d handshakes required=%0d", name, hs_count, n);
    end
    #2;
  endtask

  always @(posedge clk_i) cyc = cyc + 1;

  // Source model: pops a beat after its handshake, restarts on reset.
  always @(posedge clk_i) begin
    #1;
    for (int k = 0; k < N; k++) begin
      if (!reset_i) src_q[k].delete();
      else if (src_hs[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
      if (src_q[k].size() > 0) begin
        req_valid_i[k]         = 1'b1;
        req_data_i[k*W +: W]   = src_q[k][0].data;
        req_last_i[k]          = src_q[k][0].last;
      end else begin
        req_valid_i[k]         = 1'b0;
        req_data_i[k*W +: W]   = '0;
        req_last_i[k]          = 1'b0;
      end
    end
  end

  // Monitor: samples mid-cycle and scores every UART handshake.
  always @(negedge clk_i) begin
    exp_t e;
    src_hs = req_valid_i & req_ready_o;
    if (timeout_o) begin
      to_pulses++;
      to_cyc = cyc;
    end
    if (valid_o && ready_i) begin
      if (hs_count < 2048) hs_cyc[hs_count] = cyc;
      hs_count++;
      for (int k = 0; k < N; k++) if (grant_o[k]) gcount[k]++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat actual=%02h required=none", data_o);
      end else begin
        e = exp_q.pop_front();
        check("beat_data", {24'd0, data_o}, {24'd0, e.data});
        check("beat_grant", {29'd0, grant_o}, 32'(1 << e.src));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int req_cyc, a0, i, base;
    int g0[N];

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_valid", {31'd0, valid_o}, 0);
    check("rst_data", {24'd0, data_o}, 0);
    check("rst_req_ready", {29'd0, req_ready_o}, 0);
    check("rst_grant", {29'd0, grant_o}, 0);
    check("rst_busy", {31'd0, busy_o}, 0);
    check("rst_timeout", {31'd0, timeout_o}, 0);
    check("rst_tcount", {24'd0, timeout_count_o}, 0);
    tick();
    reset_i = 1'b1;
    @(negedge clk_i);
    check("idle_busy", {31'd0, busy_o}, 0);

    // Simultaneous 2-byte packets on 0 and 2: ptr=0 picks 0 first.
    tick();
    send(0, 8'hA1, 1'b0); send(0, 8'hA2, 1'b1);
    send(2, 8'hC1, 1'b0); send(2, 8'hC2, 1'b1);
    req_cyc = cyc + 1;
    wait_hs(4, 50, "t1_wait");
    check("t1_arb_latency", hs_cyc[0] - req_cyc, 1);
    check("t1_beat_spacing", hs_cyc[1] - hs_cyc[0], 1);
    check("t1_one_bubble", hs_cyc[2] - hs_cyc[1], 2);

    // ptr must have wrapped to 0: requester 0 wins over 2 again.
    tick();
    send(0, 8'hE0, 1'b1);
    send(2, 8'hE2, 1'b1);
    wait_hs(6, 50, "t1b_wait");

    // Single-byte packet held by a stalled sink.
    tick();
    ready_i = 1'b0;
    send(1, 8'h55, 1'b1);
    i = 0;
    do begin
      @(negedge clk_i);
      i++;
    end while (!busy_o && i < 10);
    check("t2_busy", {31'd0, busy_o}, 1);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk_i);
      check("t2_hold_valid", {31'd0, valid_o}, 1);
      check("t2_hold_data", {24'd0, data_o}, 32'h55);
      check("t2_hold_req_ready", {29'd0, req_ready_o}, 0);
    end
    check("t2_no_early_hs", hs_count, 6);
    @(posedge clk_i);
    #2;
    ready_i = 1'b1;
    wait_hs(7, 10, "t2_wait");
    @(negedge clk_i);
    check("t2_idle_after", {31'd0, busy_o}, 0);

    // Watchdog: requester 0 stalls after one byte, requester 1 waits.
    tick();
    send(0, 8'hA0, 1'b0);
    send(1, 8'h11, 1'b1);
    wait_hs(8, 50, "t3_first_byte");
    a0 = hs_cyc[7];
    i = 0;
    while (to_pulses < 1 && i < 40) begin
      @(posedge clk_i);
      i++;
    end
    check("t3_timeout_seen", to_pulses, 1);
    check("t3_timeout_cycle", to_cyc - a0, 9);
    @(negedge clk_i);
    check("t3_tcount", {24'd0, timeout_count_o}, 1);
    wait_hs(9, 30, "t3_next_grant");
    check("t3_next_grant_cycle", hs_cyc[8] - a0, 10);
    check("t3_single_pulse", to_pulses, 1);

    // Sink stall of 20 cycles mid-packet must not trip the watchdog.
    tick();
    send(0, 8'hB1, 1'b0); send(0, 8'hB2, 1'b0); send(0, 8'hB3, 1'b1);
    wait_hs(10, 50, "t4_first_byte");
    ready_i = 1'b0;
    repeat (20) tick();
    ready_i = 1'b1;
    wait_hs(12, 50, "t4_wait");
    check("t4_no_timeout", to_pulses, 1);
    @(negedge clk_i);
    check("t4_tcount", {24'd0, timeout_count_o}, 1);

    // 300 back-to-back 3-byte packets; ptr is 1 so order is 1,2,0,...
    tick();
    for (int k = 0; k < N; k++) g0[k] = gcount[k];
    base = hs_count;
    for (int p = 0; p < 100; p++) begin
      for (int r = 0; r < N; r++) begin
        int k;
        k = (r + 1) % N;
        for (int b = 0; b < 3; b++)
          send(k, 8'((k << 6) ^ (p * 3 + b)), (b == 2));
      end
    end
    wait_hs(base + 900, 3000, "t5_wait");
    check("t5_span", hs_cyc[base + 899] - hs_cyc[base], 1198);
    for (int k = 0; k < N; k++) check("t5_per_src_beats", gcount[k] - g0[k], 300);

    // Reset during the second byte of a packet.
    tick();
    send(2, 8'hD1, 1'b0); send(2, 8'hD2, 1'b0); send(2, 8'hD3, 1'b1);
    wait_hs(base + 901, 50, "t6_first_byte");
    reset_i = 1'b0;
    @(negedge clk_i);
    check("t6_rst_valid", {31'd0, valid_o}, 0);
    check("t6_rst_data", {24'd0, data_o}, 0);
    check("t6_rst_req_ready", {29'd0, req_ready_o}, 0);
    check("t6_rst_grant", {29'd0, grant_o}, 0);
    check("t6_rst_busy", {31'd0, busy_o}, 0);
    check("t6_rst_tcount", {24'd0, timeout_count_o}, 0);
    check("t6_pending_beats", exp_q.size(), 2);
    tick();
    reset_i = 1'b1;
    @(negedge clk_i);
    check("t6_post_busy", {31'd0, busy_o}, 0);
    check("t6_post_valid", {31'd0, valid_o}, 0);
    check("t6_post_tcount", {24'd0, timeout_count_o}, 0);
    check("t6_no_stale_hs", hs_count, base + 901);
    exp_q.delete();
    tick();
    send(2, 8'hD1, 1'b0); send(2, 8'hD2, 1'b0); send(2, 8'hD3, 1'b1);
    wait_hs(base + 904, 50, "t6_restart");

    repeat (3) @(posedge clk_i);
    check("sb_empty", exp_q.size(), 0);
    check("total_timeouts", to_pulses, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Packet-level round-robin scheduler that shares the single UART transmit AXI-stream port between several byte-stream requesters, such as the HSV H/V byte pair stream, a grayscale debug tap and a status/header source. It sits between the pipeline output stages and the `uart` TX slave port. Once a requester wins arbitration, it keeps the port until its packet ends, so multi-byte pixels are never interleaved. A stall watchdog releases the port if a granted source stops mid-packet.

## Interface
- `num_req_p`, 3, number of requesters (2..8)
- `data_width_p`, 8, byte width per beat
- `timeout_p`, 1024, source-stall cycles before forced release; 0 disables the watchdog
- `clk_i`  in  1  single clock
- `reset_i`  in  1  synchronous, active-low reset (0 = reset)
- `req_valid_i`  in  num_req_p  per-requester tvalid
- `req_data_i`  in  num_req_p*data_width_p  requester k occupies bits [k*data_width_p +: data_width_p]
- `req_last_i`  in  num_req_p  per-requester tlast (marks the final byte of a packet)
- `req_ready_o`  out  num_req_p  per-requester tready
- `valid_o`  out  1  to UART `s_axis_tvalid`
- `data_o`  out  data_width_p  to UART `s_axis_tdata`
- `ready_i`  in  1  from UART `s_axis_tready`
- `grant_o`  out  num_req_p  one-hot current owner; all zeros when idle
- `busy_o`  out  1  high while in LOCK
- `timeout_o`  out  1  one-cycle pulse on a forced release
- `timeout_count_o`  out  8  forced-release count, saturates at 255

## Operation
- Two states, IDLE and LOCK. The pointer `ptr` (width clog2(num_req_p)) holds the highest-priority index.
- IDLE:
  - `valid_o`=0 and all `req_ready_o`=0.
  - If any `req_valid_i` is high, pick the first asserted index scanning `ptr`, `ptr`+1, … with mod-num_req_p wrap. Register it as `gnt`, then go to LOCK.
  - The cycle after a valid request rises is spent arbitrating; no byte moves in that cycle.
- LOCK:
  - `valid_o`=`req_valid_i[gnt]`, `data_o`=`req_data_i[gnt]`, `req_ready_o[gnt]`=`ready_i`. All other `req_ready_o` are 0.
  - The data path is combinational pass-through and adds no storage.
- End of packet: a handshake (`valid_o`&&`ready_i`) with `req_last_i[gnt]`=1 sends the block to IDLE and sets `ptr`=(`gnt`+1) mod num_req_p.
- A single-byte packet (last on the first beat) is legal.
- Watchdog:
  - `stall_cnt` increments on each LOCK cycle with `req_valid_i[gnt]`=0.
  - Cycles where the sink stalls (valid=1, `ready_i`=0) do not increment it.
  - It clears on any handshake and on entry to LOCK.
  - When `stall_cnt` reaches `timeout_p`: go to IDLE, set `ptr`=`gnt`+1, pulse `timeout_o`, increment `timeout_count_o` (saturating at 255).
  - With `timeout_p`=0 the watchdog never fires.
- Boundaries:
  - Simultaneous requests are resolved purely by `ptr` order.
  - A non-granted requester that raises or drops valid has no effect on the current packet.
  - If the granted source drops valid mid-packet, the lock holds until that source resumes or the watchdog fires.
  - `req_last_i` is ignored unless it coincides with a handshake.
  - Reset mid-packet discards the lock. The UART sees no further bytes of that packet, and the requester must restart the packet.

## Timing
- Reset values while `reset_i`=0:
  - State IDLE, `ptr`=0, `gnt`=0.
  - `valid_o`=0, `data_o`=0, `req_ready_o`=0, `grant_o`=0, `busy_o`=0.
  - `timeout_o`=0, `timeout_count_o`=0, `stall_cnt`=0.
- Arbitration latency: a request first seen at cycle t has `grant_o` and `busy_o` high at t+1, and its first byte can hand off at t+1.
- Throughput: each beat of a packet can transfer every cycle. Each packet costs one IDLE bubble, so back-to-back packets to the same or different requesters are separated by exactly one cycle.
- `timeout_o` is asserted in the same cycle that the state registers show IDLE.
- Inputs are registered only through `gnt` and the state. There is one combinational path from `ready_i` to `req_ready_o`, and one from `req_valid_i`/`req_data_i` to `valid_o`/`data_o`.

## Structure
- Package `uart_sched_pkg`: state enum `{IDLE, LOCK}` and the constant `sat_count_max` = 8'hFF.
- Sub-module `rr_pick`: parameterized combinational rotate-priority picker.
  - Inputs: request vector and `ptr`.
  - Outputs: winner index and an any-request flag.
  - Reused by future RX demux and frame-buffer arbiters.
- The top module holds the state register, `gnt`/`ptr`, the watchdog counter and the output muxing.

## Test plan
- Requesters 0 and 2 both assert a 2-byte packet (0xA1,0xA2 / 0xC1,0xC2) on the same cycle after reset → UART receives A1,A2, then C1,C2; one bubble between the packets; `ptr` ends at 0.
- Requester 1 sends 0x55 with last on its first beat while `ready_i` is held low for 5 cycles → `valid_o` stays high with `data_o`=0x55; handshake on the cycle `ready_i` rises; then IDLE.
- `timeout_p`=8; requester 0 sends one byte without last, then drops valid → `timeout_o` pulses after 8 stall cycles; `timeout_count_o`=1; a pending requester 1 is granted next.
- `timeout_p`=8; requester 0 mid-packet while `ready_i` is low for 20 cycles → no timeout; packet completes intact.
- All three requesters stream continuous 3-byte packets for 300 packets → grants strictly rotate 0,1,2,…; no byte interleaving across packets; counts equal per requester.
- `reset_i` driven low for one cycle during the second byte of a packet → all outputs return to reset values the next cycle; no stale byte appears on `data_o` with `valid_o` high.
